uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  UART RX frame controller, directly upstream of the parity checker.
//  Tracks start/data/parity/stop bits from the oversampled line and deserializes data LSB-first onto P_DATA.
//  Pulses par_chk_en at the parity bit; consumes par_err; issues data_valid, strt_err and stop_err.
//  Drives the edge/bit counters and dat_samp_en used by the data sampler.
// PARAMETERS
//  DATA_WIDTH      8  data bits per frame
//  PRESCALE_WIDTH  6  width of prescale/edge_cnt; legal prescale values are 8, 16, 32
// PORTS
//  clk          in   1               system clock (oversampling clock)
//  reset_n      in   1               asynchronous active-low reset
//  RX_IN        in   1               raw serial line (idle high)
//  prescale     in   PRESCALE_WIDTH  oversampling ticks per bit; held stable during a frame
//  PAR_EN       in   1               1 = frame carries a parity bit
//  sampled_bit  in   1               majority-voted bit from sampler; valid on the end tick
//  par_err      in   1               registered parity result from checker
//  dat_samp_en  out  1               sampler enable; high in every state except IDLE
//  edge_cnt     out  PRESCALE_WIDTH  tick index within current bit, 0..prescale-1
//  bit_cnt      out  4               bit index within frame: start = 0
//  par_chk_en   out  1               parity check strobe
//  P_DATA       out  DATA_WIDTH      deserialized data
//  data_valid   out  1               one-cycle pulse; P_DATA is a good frame
//  strt_err     out  1               one-cycle pulse; false start (glitch)
//  stop_err     out  1               one-cycle pulse; stop bit sampled 0
// BEHAVIOUR
//  - Reset (async): state = IDLE; all counters, P_DATA and all outputs = 0.
//  - End tick = cycle in which edge_cnt == prescale-1.
//    On the end tick edge_cnt wraps to 0 and bit_cnt increments. Both are held at 0 in IDLE.
//  - IDLE: RX_IN == 0 -> START (edge_cnt = 0 on the next cycle).
//  - START, on end tick: sampled_bit == 0 -> DATA; otherwise pulse strt_err and go to IDLE.
//  - DATA, on each end tick: P_DATA <= {sampled_bit, P_DATA[W-1:1]}.
//    After DATA_WIDTH bits: go to PARITY if PAR_EN, else to STOP.
//  - PARITY: par_chk_en = (state == PARITY && end tick), decoded combinationally, exactly one cycle.
//    Go to STOP on the end tick. par_err is valid from the following cycle.
//  - STOP, on end tick: stop_err = ~sampled_bit.
//    data_valid = sampled_bit & ~(PAR_EN & par_err). Go to IDLE.
//  - Pulse outputs are registered; they are high in the cycle after the deciding end tick.
//  - P_DATA holds its value until the next frame's first data shift.
//  - Back-to-back frames: a start edge coincident with the stop end tick is taken in IDLE on the next cycle.
//    This one-cycle slip is tolerated.
//  - Parity-only error: data_valid = 0, stop_err = 0; the checker's par_err is the indication.
//  - RX_IN activity outside IDLE is ignored; only sampled_bit is used.
//  - Reset mid-frame: immediate return to IDLE, no pulses.
//  - Changing prescale or PAR_EN mid-frame: result undefined; the bench must not do it.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN
//   - Defined: adds output port break_det (1 bit, one-cycle pulse) and state BREAK_WAIT.
//     On the STOP end tick with P_DATA == 0 and sampled_bit == 0: pulse break_det and suppress stop_err.
//     BREAK_WAIT holds until RX_IN == 1, then goes to IDLE. dat_samp_en = 0 in BREAK_WAIT.
//   - Undefined: no break_det port, no BREAK_WAIT state; this frame gives stop_err only.
//     Re-arm on RX_IN low in IDLE.
// STRUCTURE
//  - Shared header uart_rx_defs.vh: state encoding localparams
//    (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT) and the bit_cnt width, shared with sampler and checker.
//  - One sub-module, uart_rx_edge_bit_cnt: edge/bit counters with enable from the FSM.
//  - FSM and deserializer shift register stay in this module.
// TESTING (prescale = 8 unless noted)
//  1. PAR_EN=0, frame 0xA5 with stop=1 -> P_DATA=0xA5; data_valid pulse one cycle after the stop end tick;
//     strt_err=stop_err=0; exactly 80 clocks from start edge to pulse, +1 register cycle.
//  2. PAR_EN=1, even parity, 0x3C, parity bit 0, checker connected
//     -> par_chk_en high exactly one cycle (bit_cnt=9, edge_cnt=7); data_valid=1.
//     Same frame with parity bit 1 -> par_err=1, data_valid=0, stop_err=0.
//  3. RX_IN low for 2 clocks then high, sampled_bit=1 at start end tick -> strt_err pulse, back to IDLE,
//     P_DATA unchanged, no data_valid.
//  4. Frame 0x55 with stop=0 -> stop_err pulse, data_valid=0.
//     With UART_RX_BREAK_DETECT_EN and 0x00 stop=0: break_det pulse, stop_err=0,
//     FSM stays in BREAK_WAIT until RX_IN=1.
//  5. prescale=16 and 32, two back-to-back frames 0x01, 0xFE -> two data_valid pulses with correct P_DATA each.
//  6. Assert reset_n=0 mid-DATA at bit_cnt=4 -> all outputs 0 asynchronously;
//     next clean frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared state encoding and bit counter width for the UART RX frame controller,
// sampler and parity checker.
package uart_rx_frame_ctrl_pkg;

    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_e;

    // States in which the bit timing counters run and the sampler is enabled.
    function automatic logic is_bit_state(input rx_state_e s);
        return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge (tick-within-bit) and bit (bit-within-frame) counters for the UART RX path.
// The FSM runs them while inside a frame and clears them on the way back to idle.
module uart_rx_edge_bit_cnt
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      run_i,
    input  logic                      clr_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
    output logic [BIT_CNT_W-1:0]      bit_cnt_o,
    output logic                      end_tick_o
);

    localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE = PRESCALE_WIDTH'(1);
    localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    always_comb begin
        end_tick_o = run_i && (edge_cnt_q == (prescale_i - EDGE_ONE));
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (run_i) begin
            if (end_tick_o) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_ONE;
            end else begin
                edge_cnt_d = edge_cnt_q + EDGE_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start/data/parity/stop sequencing and LSB-first deserializer.
// Optional break detection (break_det port, BREAK_WAIT state) under UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic                      sampled_bit,
    input  logic                      par_err,
    output logic                      dat_samp_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      par_chk_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                      break_det,
`endif
    output logic                      data_valid,
    output logic                      strt_err,
    output logic                      stop_err
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

    rx_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      strt_err_q, strt_err_d;
    logic                      stop_err_q, stop_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                      break_det_q, break_det_d;
`endif
    logic                      end_tick;
    logic                      cnt_run;
    logic                      cnt_clr;
    logic [BIT_CNT_W-1:0]      bit_cnt_w;

    // Counters hold at zero in the first START cycle because run follows the
    // registered state while clear follows the next state.
    assign cnt_run = is_bit_state(state_q);
    assign cnt_clr = !is_bit_state(state_d);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_edge_bit_cnt (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .run_i      (cnt_run),
        .clr_i      (cnt_clr),
        .prescale_i (prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt_w),
        .end_tick_o (end_tick)
    );

    always_comb begin
        state_d      = state_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        strt_err_d   = 1'b0;
        stop_err_d   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        break_det_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) state_d = ST_START;
            end
            ST_START: begin
                if (end_tick) begin
                    if (!sampled_bit) begin
                        state_d = ST_DATA;
                    end else begin
                        strt_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (end_tick) begin
                    p_data_d = {sampled_bit, p_data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_w == LAST_DATA_BIT) begin
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (end_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (end_tick) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    // All-zero data with a low stop bit is a line break, not a framing error.
                    if ((p_data_q == '0) && !sampled_bit) begin
                        break_det_d = 1'b1;
                        state_d     = ST_BREAK_WAIT;
                    end else begin
                        stop_err_d   = ~sampled_bit;
                        data_valid_d = sampled_bit & ~(PAR_EN & par_err);
                        state_d      = ST_IDLE;
                    end
`else
                    stop_err_d   = ~sampled_bit;
                    data_valid_d = sampled_bit & ~(PAR_EN & par_err);
                    state_d      = ST_IDLE;
`endif
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            ST_BREAK_WAIT: begin
                if (RX_IN) state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            strt_err_q   <= 1'b0;
            stop_err_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            strt_err_q   <= strt_err_d;
            stop_err_q   <= stop_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det_q  <= break_det_d;
`endif
        end
    end

    assign dat_samp_en = cnt_run;
    assign par_chk_en  = (state_q == ST_PARITY) && end_tick;
    assign bit_cnt     = bit_cnt_w;
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign strt_err    = strt_err_q;
    assign stop_err    = stop_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det   = break_det_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl; the bench plays sampler and parity checker.
module tb_uart_rx_frame_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          sampled_bit = 1'b1;
    logic          par_err;
    logic          dat_samp_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          par_chk_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          strt_err;
    logic          stop_err;
`ifdef UART_RX_BREAK_DETECT_EN
    logic          break_det;
`endif

    uart_rx_frame_ctrl #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .sampled_bit (sampled_bit),
        .par_err     (par_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .par_chk_en  (par_chk_en),
        .P_DATA      (P_DATA),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det   (break_det),
`endif
        .data_valid  (data_valid),
        .strt_err    (strt_err),
        .stop_err    (stop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Even-parity checker model: registered result, valid the cycle after the strobe.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_err <= 1'b0;
        else if (par_chk_en) par_err <= (^P_DATA) ^ sampled_bit;
    end

    int          dv_cnt, strt_cnt, stop_cnt, pce_cnt, brk_cnt;
    int          dv_cyc, start_cyc;
    logic [7:0]  dv_log [0:7];
    logic [3:0]  pce_bit;
    logic [PW-1:0] pce_edge;

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_cnt < 8) dv_log[dv_cnt] = P_DATA;
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (strt_err) strt_cnt = strt_cnt + 1;
        if (stop_err) stop_cnt = stop_cnt + 1;
        if (par_chk_en) begin
            pce_cnt  = pce_cnt + 1;
            pce_bit  = bit_cnt;
            pce_edge = edge_cnt;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_det) brk_cnt = brk_cnt + 1;
`endif
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        dv_cnt = 0; strt_cnt = 0; stop_cnt = 0; pce_cnt = 0; brk_cnt = 0;
        pce_bit = '0; pce_edge = '0;
        for (int i = 0; i < 8; i++) dv_log[i] = 8'hxx;
    endtask

    // Called at a negedge; holds line and sampler output across n rising edges.
    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        sampled_bit = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        int p;
        p = int'(prescale);
        start_cyc = cyc + 1;
        drive_bit(1'b0, 1);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (has_par) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    initial begin
        clr_mon();
        dv_cyc = 0; start_cyc = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {9'd0, dat_samp_en, edge_cnt, bit_cnt, par_chk_en, P_DATA,
                                data_valid, strt_err, stop_err}, 32'd0);

        // 1: no parity, 0xA5
        clr_mon();
        PAR_EN = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("t1_dv_cnt", dv_cnt, 1);
        check("t1_pdata", dv_log[0], 8'hA5);
        check("t1_errs", strt_cnt + stop_cnt, 0);
        check("t1_latency", dv_cyc - start_cyc, 80);
        idle(16);
        check("t1_pdata_hold", P_DATA, 8'hA5);
        check("t1_idle_en", dat_samp_en, 1'b0);

        // 2: even parity, 0x3C, good then bad parity bit
        clr_mon();
        PAR_EN = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("t2_pce_cnt", pce_cnt, 1);
        check("t2_pce_bit", pce_bit, 4'd9);
        check("t2_pce_edge", pce_edge, 6'd7);
        check("t2_dv_cnt", dv_cnt, 1);
        check("t2_pdata", dv_log[0], 8'h3C);
        clr_mon();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("t2b_par_err", par_err, 1'b1);
        check("t2b_dv_cnt", dv_cnt, 0);
        check("t2b_stop_cnt", stop_cnt, 0);
        check("t2b_pce_cnt", pce_cnt, 1);
        PAR_EN = 1'b0;

        // 3: false start
        clr_mon();
        drive_bit(1'b0, 2);
        idle(12);
        check("t3_strt_cnt", strt_cnt, 1);
        check("t3_dv_cnt", dv_cnt, 0);
        check("t3_pdata", P_DATA, 8'h3C);
        check("t3_idle_en", dat_samp_en, 1'b0);

        // 4: stop bit low
        clr_mon();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("t4_stop_cnt", stop_cnt, 1);
        check("t4_dv_cnt", dv_cnt, 0);
        check("t4_pdata", P_DATA, 8'h55);
        clr_mon();
`ifdef UART_RX_BREAK_DETECT_EN
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 6);
        check("t4b_brk_cnt", brk_cnt, 1);
        check("t4b_stop_cnt", stop_cnt, 0);
        check("t4b_wait_en", dat_samp_en, 1'b0);
        check("t4b_wait_bitcnt", bit_cnt, 4'd0);
        idle(2);
        check("t4b_idle_en", dat_samp_en, 1'b0);
`else
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("t4b_stop_cnt", stop_cnt, 1);
        check("t4b_dv_cnt", dv_cnt, 0);
        check("t4b_rearm_en", dat_samp_en, 1'b0);
`endif

        // 5: back-to-back frames at prescale 16 and 32
        for (int k = 0; k < 2; k++) begin
            prescale = (k == 0) ? 6'd16 : 6'd32;
            idle(2);
            clr_mon();
            send_frame(8'h01, 1'b0, 1'b0, 1'b1);
            send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
            idle(4);
            check("t5_dv_cnt", dv_cnt, 2);
            check("t5_pdata0", dv_log[0], 8'h01);
            check("t5_pdata1", dv_log[1], 8'hFE);
            check("t5_errs", strt_cnt + stop_cnt, 0);
        end
        prescale = 6'd8;
        idle(2);

        // 6: reset in the middle of DATA
        clr_mon();
        drive_bit(1'b0, 1);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        check("t6_bitcnt", bit_cnt, 4'd4);
        check("t6_edgecnt", edge_cnt, 6'd0);
        drive_bit(1'b0, 3);
        check("t6_edgecnt_run", edge_cnt, 6'd3);
        reset_n = 1'b0;
        #1;
        check("t6_async_reset", {9'd0, dat_samp_en, edge_cnt, bit_cnt, par_chk_en, P_DATA,
                                 data_valid, strt_err, stop_err}, 32'd0);
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        check("t6_no_pulse", dv_cnt + strt_cnt + stop_cnt, 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("t6_dv_cnt", dv_cnt, 1);
        check("t6_pdata", dv_log[0], 8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
